// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register bank with write-to-read bypass and pending-write scoreboard
module reg_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     issue_en,
  input  logic [ADDR_W-1:0]        issue_addr,
  input  logic                     flush,
  output logic                     any_busy
);
  localparam int NUM_REGS = 2**ADDR_W;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic                any_busy_q, any_busy_d;
  logic                wr_ok;
  assign wr_ok = wr_en && !(ZERO_REG && wr_addr == '0);
  // next state: write, then scoreboard in rising priority (writeback clear, issue set, flush)
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    if (issue_en) pend_d[issue_addr] = 1'b1;
    if (flush) pend_d = '0;
    if (ZERO_REG) pend_d[0] = 1'b0;
    any_busy_d = |pend_d;
  end
  // state registers, cleared asynchronously
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regs_q     <= '{default: '0};
      pend_q     <= '0;
      any_busy_q <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      pend_q     <= pend_d;
      any_busy_q <= any_busy_d;
    end
  end
  assign any_busy = any_busy_q;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              zero, byp;
    assign a    = rd_addr[k*ADDR_W +: ADDR_W];
    assign zero = ZERO_REG && a == '0;
    assign byp  = reset && wr_en && wr_addr == a;
    assign rd_data[k*DATA_W +: DATA_W] = zero ? '0 : byp ? wr_data : regs_q[a];
    assign rd_busy[k] = !(zero || byp) && pend_q[a];
  end
endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the decode-stage register bank, used by the pipelined MIPS decode stage.
- Configurable data width, register count and number of read ports, with an optional hardwired zero register.
- Write-to-read bypass: a read in the same cycle as a write to that register returns the new value.
- Per-register scoreboard of pending writes. Decode sets a bit when it issues an instruction and writeback clears it. Decode uses the busy flags to stall.

Parameters:
DATA_W, 32, width of each register in bits
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W
NUM_RD, 2, number of independent read ports (1..4)
ZERO_REG, 1, 1 = register 0 always reads 0, is never written and is never pending; 0 = register 0 is an ordinary register

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
rd_addr  input  NUM_RD*ADDR_W  read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  output  NUM_RD*DATA_W  read data; port k uses bits [k*DATA_W +: DATA_W]
rd_busy  output  NUM_RD  1 = register read by port k has a pending write
wr_en  input  1  writeback strobe
wr_addr  input  ADDR_W  writeback destination
wr_data  input  DATA_W  writeback value
issue_en  input  1  decode issued an instruction that writes issue_addr
issue_addr  input  ADDR_W  destination to mark pending
flush  input  1  clears all pending bits (pipeline squash)
any_busy  output  1  OR of all pending bits (drain indicator)

Behaviour:
- Clock and reset: one clock domain. reset is asynchronous and active-low.
- While reset=0:
  - all registers and pending bits are forced to 0;
  - rd_data reads 0, rd_busy=0, any_busy=0;
  - wr_en, issue_en and flush are ignored.
- Reset release: takes effect at the next rising edge; no extra latency.
- Write:
  - On a rising edge with wr_en=1, regs[wr_addr] <= wr_data.
  - If ZERO_REG=1 and wr_addr=0, the write is dropped.
- Read (combinational, zero latency), per port k with address a:
  - If ZERO_REG=1 and a=0: rd_data=0, rd_busy=0.
  - Else if wr_en=1 and wr_addr=a: bypass, so rd_data=wr_data and rd_busy=0 (the writeback completes this cycle).
  - Else: rd_data=regs[a], rd_busy=pending[a].
  - Multiple ports may read the same address; all receive identical results.
- Scoreboard, per register r, next pending[r], in priority order:
  1. flush=1 -> 0 for every r. A simultaneous issue_en is ignored; the data write still occurs.
  2. issue_en=1 and issue_addr=r -> 1. This wins over a same-cycle writeback to r, because the new producer supersedes the completing one.
  3. wr_en=1 and wr_addr=r -> 0.
  4. Otherwise hold.
  - With ZERO_REG=1, pending[0] is constant 0.
- Timing of issue: a same-cycle issue does not affect rd_busy in that cycle. It becomes visible on the cycle after the edge.
- any_busy: registered OR of all pending bits, reflecting state after the most recent edge.
- No wrap or overflow concerns: each pending bit is 1 bit. A repeated issue to an already-pending register leaves it at 1. A single writeback clears it regardless of issue count, because the pipeline guarantees in-order writeback per register.
- Reset mid-operation: every in-flight pending bit and register value is discarded immediately (asynchronous).
- X-free: every output is defined from reset onward. Out-of-range addresses cannot occur because the address width covers every register.

Test Plan:
1. Reset and basic read/write: reset=0 then release; write r5=0xDEADBEEF; next cycle rd_addr port0=5 -> rd_data=0xDEADBEEF, rd_busy=0; port1=6 -> 0.
2. Zero register: wr_en, wr_addr=0, wr_data=0x1234 and issue_addr=0 -> port0 reading 0 returns 0 with rd_busy=0 on both the same and the next cycle; any_busy=0. Repeat with ZERO_REG=0 -> reads 0x1234.
3. Bypass: wr_en, wr_addr=9, wr_data=0xA5A5A5A5 while both ports read 9 in the same cycle -> both rd_data=0xA5A5A5A5, rd_busy=0. Prior stored value 0x1 is not visible.
4. Scoreboard lifecycle:
   - issue r7 at cycle t -> rd_busy port0 (addr 7) is 0 at t and 1 at t+1; any_busy=1 from t+1.
   - writeback r7 at t+3 -> rd_busy=0 at t+3 via bypass; pending clear from t+4; any_busy=0 at t+4.
5. Simultaneous events:
   - issue r3 and writeback r3 in the same cycle -> r3 data updated, pending[3]=1 afterwards.
   - flush together with issue r4 -> all pending 0, r4 not pending.
6. Asynchronous reset mid-operation: with r2=0x55 and pending[2]=1, assert reset between clock edges -> rd_data=0 and rd_busy=0 immediately, without waiting for an edge. After release, r2 reads 0 and any_busy=0.
